// File: rtl/alu_flag_stage.sv
// ALU flag stage: registers one ALU outcome for downstream writeback and
// owns the architectural carry/zero flags. Conditional instructions whose
// condition fails are still passed downstream (to keep ordering) but with
// writeback disabled, and they are counted in a saturating squash counter.
module alu_flag_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic [1:0]  in_cond,
  input  logic        in_set_c,
  input  logic        in_set_z,
  input  logic [2:0]  in_rd,
  input  logic        in_wb_en,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_rd,
  output logic        out_wb_en,
  output logic        c_flag,
  output logic        z_flag,
  output logic [7:0]  squash_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] result_q, result_d;
  logic [2:0]  rd_q, rd_d;
  logic        wbEn_q, wbEn_d;
  logic        cFlag_q, cFlag_d;
  logic        zFlag_q, zFlag_d;
  logic [7:0]  squashCnt_q, squashCnt_d;

  logic        accept;
  logic        condPass;

  // The slot can take a new entry when it is empty or is being drained this
  // cycle; flush and reset both refuse the incoming instruction.
  assign in_ready = ((state_q == EMPTY) | out_ready) & ~flush & ~rst;
  assign accept   = in_valid & in_ready;

  // Condition check uses the flag registers as they stand before the edge,
  // so a dependent instruction sees the flags of the one accepted just before.
  always_comb begin
    condPass = 1'b1;
    case (in_cond)
      2'b10:   condPass = cFlag_q;
      2'b01:   condPass = zFlag_q;
      default: condPass = 1'b1;
    endcase
  end

  // Next-state logic: load entry on accept, update flags only for executed
  // instructions, count squashed ones, otherwise drain or drop on flush.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    rd_d        = rd_q;
    wbEn_d      = wbEn_q;
    cFlag_d     = cFlag_q;
    zFlag_d     = zFlag_q;
    squashCnt_d = squashCnt_q;

    if (accept) begin
      state_d  = FULL;
      result_d = alu_result;
      rd_d     = in_rd;
      if (condPass) begin
        wbEn_d = in_wb_en;
        if (in_set_c) cFlag_d = alu_carry;
        if (in_set_z) zFlag_d = alu_zero;
      end else begin
        wbEn_d = 1'b0;
        if (squashCnt_q != 8'hFF) squashCnt_d = squashCnt_q + 8'd1;
      end
    end else if (flush || ((state_q == FULL) && out_ready)) begin
      state_d = EMPTY;
    end
  end

  // State and datapath registers with synchronous reset clearing everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      result_q    <= 16'h0000;
      rd_q        <= 3'd0;
      wbEn_q      <= 1'b0;
      cFlag_q     <= 1'b0;
      zFlag_q     <= 1'b0;
      squashCnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      wbEn_q      <= wbEn_d;
      cFlag_q     <= cFlag_d;
      zFlag_q     <= zFlag_d;
      squashCnt_q <= squashCnt_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign out_wb_en  = wbEn_q;
  assign c_flag     = cFlag_q;
  assign z_flag     = zFlag_q;
  assign squash_cnt = squashCnt_q;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed testbench for alu_flag_stage with a cycle-level reference model
// and a single per-cycle comparator, plus literal expectations at key points.
module tb_alu_flag_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic [1:0]  in_cond;
  logic        in_set_c;
  logic        in_set_z;
  logic [2:0]  in_rd;
  logic        in_wb_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wb_en;
  logic        c_flag;
  logic        z_flag;
  logic [7:0]  squash_cnt;

  int errors = 0;
  int checks = 0;
  bit checkEn = 0;

  // Reference model state
  logic        mValid;
  logic [15:0] mResult;
  logic [2:0]  mRd;
  logic        mWb;
  logic        mC;
  logic        mZ;
  int          mSq;

  alu_flag_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .in_cond    (in_cond),
    .in_set_c   (in_set_c),
    .in_set_z   (in_set_z),
    .in_rd      (in_rd),
    .in_wb_en   (in_wb_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wb_en  (out_wb_en),
    .c_flag     (c_flag),
    .z_flag     (z_flag),
    .squash_cnt (squash_cnt)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return just after it.
  task automatic applyStimulus(input logic v, input logic [15:0] res, input logic c, input logic z,
                               input logic [1:0] cond, input logic sc, input logic sz,
                               input logic [2:0] rd, input logic wb, input logic ordy,
                               input logic fl);
    in_valid   = v;
    alu_result = res;
    alu_carry  = c;
    alu_zero   = z;
    in_cond    = cond;
    in_set_c   = sc;
    in_set_z   = sz;
    in_rd      = rd;
    in_wb_en   = wb;
    out_ready  = ordy;
    flush      = fl;
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: what the stage must hold after each edge.
  always @(posedge clk) begin
    bit rdy;
    bit take;
    if (rst) begin
      mValid  = 1'b0;
      mResult = 16'h0;
      mRd     = 3'd0;
      mWb     = 1'b0;
      mC      = 1'b0;
      mZ      = 1'b0;
      mSq     = 0;
    end else begin
      rdy = (!mValid || out_ready) && !flush;
      if (in_valid && rdy) begin
        if (in_cond == 2'b10)      take = mC;
        else if (in_cond == 2'b01) take = mZ;
        else                       take = 1'b1;
        mValid  = 1'b1;
        mResult = alu_result;
        mRd     = in_rd;
        if (take) begin
          mWb = in_wb_en;
          if (in_set_c) mC = alu_carry;
          if (in_set_z) mZ = alu_zero;
        end else begin
          mWb = 1'b0;
          mSq = (mSq < 255) ? mSq + 1 : 255;
        end
      end else if (flush || out_ready) begin
        mValid = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("in_ready",   in_ready,   ((!mValid || out_ready) && !flush && !rst));
      checkOutput("out_valid",  out_valid,  mValid);
      checkOutput("out_result", out_result, mResult);
      checkOutput("out_rd",     out_rd,     mRd);
      checkOutput("out_wb_en",  out_wb_en,  mWb);
      checkOutput("c_flag",     c_flag,     mC);
      checkOutput("z_flag",     z_flag,     mZ);
      checkOutput("squash_cnt", squash_cnt, mSq[7:0]);
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 16'h0, 0, 0, 2'b00, 0, 0, 3'd0, 0, 1, 0);
    applyStimulus(0, 16'h0, 0, 0, 2'b00, 0, 0, 3'd0, 0, 1, 0);
    checkEn = 1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_flags", {c_flag, z_flag}, 2'b00);
    checkOutput("rst_squash", squash_cnt, 0);
    rst = 1'b0;

    // ADD with carry and zero set
    applyStimulus(1, 16'h0000, 1, 1, 2'b00, 1, 1, 3'd3, 1, 1, 0);
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_result", out_result, 16'h0000);
    checkOutput("add_rd", out_rd, 3);
    checkOutput("add_wb", out_wb_en, 1);
    checkOutput("add_flags", {c_flag, z_flag}, 2'b11);

    // Clear C only
    applyStimulus(1, 16'h5555, 0, 0, 2'b00, 1, 0, 3'd1, 1, 1, 0);
    checkOutput("clrc_flags", {c_flag, z_flag}, 2'b01);

    // Conditional on C with C=0 -> squashed
    applyStimulus(1, 16'h1234, 1, 0, 2'b10, 1, 1, 3'd2, 1, 1, 0);
    checkOutput("sq_result", out_result, 16'h1234);
    checkOutput("sq_wb", out_wb_en, 0);
    checkOutput("sq_flags", {c_flag, z_flag}, 2'b01);
    checkOutput("sq_cnt", squash_cnt, 1);

    // Clear Z, then set Z, then dependent cond=01 executes with set_c=0
    applyStimulus(1, 16'h0001, 0, 0, 2'b00, 0, 1, 3'd4, 1, 1, 0);
    checkOutput("clrz_flags", {c_flag, z_flag}, 2'b00);
    applyStimulus(1, 16'h0000, 1, 1, 2'b00, 0, 1, 3'd4, 0, 1, 0);
    checkOutput("setz_flags", {c_flag, z_flag}, 2'b01);
    applyStimulus(1, 16'hBEEF, 1, 0, 2'b01, 0, 0, 3'd5, 1, 1, 0);
    checkOutput("dep_wb", out_wb_en, 1);
    checkOutput("dep_rd", out_rd, 5);
    checkOutput("dep_c_hold", c_flag, 0);
    // cond=11 behaves as always-execute even with C=0 and Z=0
    applyStimulus(1, 16'hBEEF, 0, 0, 2'b11, 0, 1, 3'd5, 1, 1, 0);
    checkOutput("cond11_wb", out_wb_en, 1);
    checkOutput("cond11_sq", squash_cnt, 1);

    // Backpressure for 3 cycles with a pending input
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 16'hAAAA, 1, 1, 2'b00, 1, 1, 3'd6, 1, 0, 0);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_result", out_result, 16'hBEEF);
      checkOutput("bp_flags", {c_flag, z_flag}, 2'b00);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", in_ready, 1);
    applyStimulus(1, 16'hAAAA, 1, 1, 2'b00, 1, 1, 3'd6, 1, 1, 0);
    checkOutput("bp_release_valid", out_valid, 1);
    checkOutput("bp_release_result", out_result, 16'hAAAA);
    checkOutput("bp_release_flags", {c_flag, z_flag}, 2'b11);

    // Drain to EMPTY
    applyStimulus(0, 16'h0, 0, 0, 2'b00, 0, 0, 3'd0, 0, 1, 0);
    checkOutput("drain_valid", out_valid, 0);

    // Clear C, then 260 squashed conditionals saturate the counter
    applyStimulus(1, 16'h0002, 0, 0, 2'b00, 1, 0, 3'd1, 1, 1, 0);
    for (int i = 0; i < 260; i++)
      applyStimulus(1, 16'h0100 + 16'(i), 1, 1, 2'b10, 1, 1, 3'd7, 1, 1, 0);
    checkOutput("sat_cnt", squash_cnt, 255);
    checkOutput("sat_wb", out_wb_en, 0);

    // Flush while FULL with a valid input
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    checkOutput("flush_in_ready", in_ready, 0);
    applyStimulus(1, 16'h7777, 1, 1, 2'b00, 1, 1, 3'd2, 1, 1, 1);
    checkOutput("flush_valid", out_valid, 0);
    checkOutput("flush_result", out_result, 16'h0100 + 16'd259);
    checkOutput("flush_flags", {c_flag, z_flag}, 2'b01);
    checkOutput("flush_cnt", squash_cnt, 255);

    // Refill with C=Z=1, hold, then reset mid-operation
    applyStimulus(1, 16'h4321, 1, 1, 2'b00, 1, 1, 3'd3, 1, 1, 0);
    applyStimulus(1, 16'h9999, 0, 0, 2'b00, 1, 1, 3'd1, 1, 0, 0);
    checkOutput("pre_rst_flags", {c_flag, z_flag}, 2'b11);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_in_ready", in_ready, 0);
    applyStimulus(1, 16'h9999, 0, 0, 2'b00, 1, 1, 3'd1, 1, 1, 0);
    checkOutput("rst_mid_valid", out_valid, 0);
    checkOutput("rst_mid_result", {out_result, out_rd, out_wb_en}, 0);
    checkOutput("rst_mid_flags", {c_flag, z_flag}, 2'b00);
    checkOutput("rst_mid_cnt", squash_cnt, 0);
    rst = 1'b0;
    applyStimulus(0, 16'h0, 0, 0, 2'b00, 0, 0, 3'd0, 0, 1, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_flag_stage.md
ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Interface
- REQ-001: clk  input  1  single clock; all state updates on rising edge.
- REQ-002: rst  input  1  synchronous, active-high reset.
- REQ-003: in_valid  input  1  upstream holds valid ALU outcome this cycle.
- REQ-004: in_ready  output  1  block accepts the input this cycle.
- REQ-005: alu_result  input  16  ALU result word.
- REQ-006: alu_carry  input  1  ALU carry_out.
- REQ-007: alu_zero  input  1  ALU zero_out.
- REQ-008: in_cond  input  2  00 always execute; 10 execute if C=1; 01 execute if Z=1; 11 treated as 00.
- REQ-009: in_set_c  input  1  accepted, executed instruction writes C.
- REQ-010: in_set_z  input  1  accepted, executed instruction writes Z.
- REQ-011: in_rd  input  3  destination register index.
- REQ-012: in_wb_en  input  1  instruction requests register writeback.
- REQ-013: flush  input  1  discard held entry and same-cycle input.
- REQ-014: out_valid  output  1  output register holds an entry.
- REQ-015: out_ready  input  1  downstream consumes entry this cycle.
- REQ-016: out_result  output  16  registered result.
- REQ-017: out_rd  output  3  registered destination index.
- REQ-018: out_wb_en  output  1  registered writeback enable, cleared for squashed instructions.
- REQ-019: c_flag, z_flag  output  1 each  architectural carry/zero flags.
- REQ-020: squash_cnt  output  8  saturating count of condition-failed instructions.

Function
- REQ-021: Two states, EMPTY (out_valid=0) and FULL (out_valid=1); in_ready SHALL be combinational: (!out_valid | out_ready) & !flush.
- REQ-022: accept = in_valid & in_ready; on accept, out_result/out_rd/out_wb_en SHALL load next cycle (latency 1), state goes FULL.
- REQ-023: pass = (in_cond==10 ? c_flag : in_cond==01 ? z_flag : 1), evaluated against flag register values before the edge.
- REQ-024: On accept with pass=1: out_wb_en <= in_wb_en; c_flag <= alu_carry if in_set_c; z_flag <= alu_zero if in_set_z; unselected flags hold.
- REQ-025: On accept with pass=0: entry still loads (order preserved), out_wb_en <= 0, flags SHALL NOT change, squash_cnt increments, saturating at 255.
- REQ-026: FULL with out_ready=1 and no accept -> EMPTY; FULL with out_ready=1 and accept -> FULL with new entry, no bubble.
- REQ-027: FULL with out_ready=0 -> entry and flags hold; in_ready=0.
- REQ-028: flush=1 -> next cycle EMPTY, input not accepted, flags and squash_cnt unchanged, out_result/out_rd/out_wb_en retain values.
- REQ-029: Back-to-back dependent conditionals SHALL see flags written by the immediately preceding accepted instruction (flags update at accept edge).
- REQ-030: Outputs out_result/out_rd/out_wb_en SHALL be stable while out_valid=1 and out_ready=0.

Reset
- REQ-031: rst=1 at an edge SHALL force out_valid=0, out_result=0, out_rd=0, out_wb_en=0, c_flag=0, z_flag=0, squash_cnt=0; rst dominates flush and accept.
- REQ-032: Reset mid-operation SHALL drop any held entry; in_ready SHALL be 0 during the reset cycle.

Verification
- REQ-033: ADD accept alu_result=0x0000, alu_carry=1, alu_zero=1, cond=00, set_c=set_z=1, rd=3, wb_en=1 -> next cycle out_valid=1, out_result=0x0000, out_rd=3, out_wb_en=1, c_flag=1, z_flag=1.
- REQ-034: C=0, accept cond=10 result=0x1234 wb_en=1 -> out_result=0x1234, out_wb_en=0, flags unchanged, squash_cnt +1.
- REQ-035: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output and flags stable; release out_ready -> pending input accepted same cycle, no bubble.
- REQ-036: Accept set_z=1 alu_zero=1, then next cycle cond=01 -> executes (out_wb_en=in_wb_en); NDU-style set_c=0 leaves C unchanged.
- REQ-037: 260 squashed instructions -> squash_cnt=255; flush while FULL with in_valid=1 -> out_valid=0 next cycle, input dropped, flags unchanged.
- REQ-038: rst asserted while FULL, C=Z=1 -> all outputs 0 next cycle.
